// File: rtl/mat_pkg.sv
// mat_pkg: constants and types shared by the matrix-engine host link.
// Holds the reply-frame sync/tag bytes, the frame length, the result
// framer state encoding and the frame checksum helper. The host-facing
// request parser reuses SYNC_BYTE and TAG_RESULT for its own decoding.
package mat_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hFF;
    localparam logic [7:0] TAG_RESULT = 8'h02;
    localparam int         FRAME_LEN  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } frame_state_e;

    // Checksum covers every byte after the sync byte: tag, job and results.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0] job,
        input logic [7:0] c11,
        input logic [7:0] c12,
        input logic [7:0] c21,
        input logic [7:0] c22
    );
        frame_checksum = TAG_RESULT ^ job ^ c11 ^ c12 ^ c21 ^ c22;
    endfunction

endpackage

// File: rtl/result_framer_if.sv
// result_framer_if: bundles the result handshake from mat_mul and the
// byte start/busy handshake toward the UART transmitter.
//   res_valid/res_ready   result handshake, accept on valid & ready
//   res_job, res_c11..22  result set (8 bits each)
//   tx_byte/tx_start      byte offered to the UART with one-cycle start
//   tx_busy               UART is shifting a byte
// modport slave  : the framer's view.
// modport master : the surrounding environment (mat_mul + UART) view.
interface result_framer_if;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_job;
    logic [7:0] res_c11;
    logic [7:0] res_c12;
    logic [7:0] res_c21;
    logic [7:0] res_c22;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;

    modport slave (
        input  res_valid, res_job, res_c11, res_c12, res_c21, res_c22,
        output res_ready,
        output tx_byte, tx_start,
        input  tx_busy
    );

    modport master (
        output res_valid, res_job, res_c11, res_c12, res_c21, res_c22,
        input  res_ready,
        input  tx_byte, tx_start,
        output tx_busy
    );

endinterface

// File: rtl/result_framer.sv
// result_framer: wraps one 2x2 matrix result set into an 8-byte reply
// frame (FF, 02, job, c11, c12, c21, c22, checksum) and feeds it to the
// UART one byte at a time using a start/busy handshake.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset, aborts any frame in flight
//   bus         result_framer_if.slave (result handshake + UART byte port)
//   frame_done  one-cycle pulse after the checksum byte has left the UART
//   frame_err   one-cycle pulse when the UART never acknowledged a start
// Parameter ACK_TIMEOUT: WAIT_ACK cycles allowed for tx_busy to rise.
module result_framer
    import mat_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    result_framer_if.slave bus,
    output logic           frame_done,
    output logic           frame_err
);

    localparam int         CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

    frame_state_e     state_r;
    frame_state_e     next_state_s;
    logic [2:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       job_r;
    logic [7:0]       c11_r;
    logic [7:0]       c12_r;
    logic [7:0]       c21_r;
    logic [7:0]       c22_r;
    logic [7:0]       csum_r;
    logic [7:0]       tx_byte_r;
    logic             tx_start_r;
    logic             done_r;
    logic             err_r;
    logic             ready_r;
    logic [7:0]       frame_byte_s;
    logic             accept_s;
    logic             issue_s;
    logic             advance_s;
    logic             cnt_inc_s;
    logic             done_s;
    logic             err_s;

    assign bus.res_ready = ready_r;
    assign bus.tx_byte   = tx_byte_r;
    assign bus.tx_start  = tx_start_r;
    assign frame_done    = done_r;
    assign frame_err     = err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        advance_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.res_valid && ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = SEND;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SEND: begin
                // Never start while the UART is still shifting.
                if (!bus.tx_busy) begin
                    issue_s      = 1'b1;
                    next_state_s = WAIT_ACK;
                end else begin
                    next_state_s = SEND;
                end
            end
            WAIT_ACK: begin
                // A busy rise wins over a timeout landing in the same cycle.
                if (bus.tx_busy) begin
                    next_state_s = WAIT_DONE;
                end else if (cnt_r == LAST_CNT) begin
                    err_s        = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    cnt_inc_s    = 1'b1;
                    next_state_s = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (idx_r == LAST_IDX) begin
                        done_s       = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        advance_s    = 1'b1;
                        next_state_s = SEND;
                    end
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Frame byte select on the current index.
    always_comb begin
        frame_byte_s = SYNC_BYTE;
        case (idx_r)
            3'd0:    frame_byte_s = SYNC_BYTE;
            3'd1:    frame_byte_s = TAG_RESULT;
            3'd2:    frame_byte_s = job_r;
            3'd3:    frame_byte_s = c11_r;
            3'd4:    frame_byte_s = c12_r;
            3'd5:    frame_byte_s = c21_r;
            3'd6:    frame_byte_s = c22_r;
            3'd7:    frame_byte_s = csum_r;
            default: frame_byte_s = SYNC_BYTE;
        endcase
    end

    // Captured result set, index, ack timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r      <= 3'd0;
            cnt_r      <= '0;
            job_r      <= 8'h00;
            c11_r      <= 8'h00;
            c12_r      <= 8'h00;
            c21_r      <= 8'h00;
            c22_r      <= 8'h00;
            csum_r     <= 8'h00;
            tx_byte_r  <= 8'h00;
            tx_start_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                idx_r  <= 3'd0;
                job_r  <= bus.res_job;
                c11_r  <= bus.res_c11;
                c12_r  <= bus.res_c12;
                c21_r  <= bus.res_c21;
                c22_r  <= bus.res_c22;
                csum_r <= frame_checksum(bus.res_job, bus.res_c11, bus.res_c12,
                                         bus.res_c21, bus.res_c22);
            end else if (advance_s) begin
                idx_r <= idx_r + 3'd1;
            end
            if (issue_s) begin
                tx_byte_r <= frame_byte_s;
                cnt_r     <= '0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            tx_start_r <= issue_s;
            done_r     <= done_s;
            err_r      <= err_s;
            // Ready only after a full cycle in IDLE, so the done/err cycle
            // itself can never accept a new result.
            ready_r    <= (state_r == IDLE) && (next_state_s == IDLE);
        end
    end

endmodule

// File: tb/tb_result_framer.sv
// tb_result_framer: randomized self-checking bench for result_framer.
// A model UART answers tx_start with a busy pulse; every byte seen on a
// tx_start is logged and compared with frames built from the result
// sets the bench submitted.
`timescale 1ns/1ps
module tb_result_framer;

    localparam int AT     = 16;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_done;
    logic frame_err;

    result_framer_if bus();

    logic uart_busy  = 1'b0;
    logic force_busy = 1'b0;
    logic uart_dead  = 1'b0;
    int   uart_dly   = 1;
    int   uart_len   = 10;

    assign bus.tx_busy = uart_busy | force_busy;

    result_framer #(.ACK_TIMEOUT(AT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic busy_q = 1'b0;
    int starts = 0, dones = 0, errs = 0, viol = 0;
    int last_start_cyc = 0, last_done_cyc = 0, last_err_cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int got_base = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference frame from the result set; nbytes limits it for aborted frames.
    task automatic push_frame(input logic [7:0] j, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input int nbytes);
        logic [7:0] f[8];
        f = '{8'hFF, 8'h02, j, a, b, c, d, 8'h00};
        for (int i = 1; i < 7; i++) f[7] = f[7] ^ f[i];
        for (int i = 0; i < nbytes; i++) exp_q.push_back(f[i]);
    endtask

    task automatic drive_result(input logic [7:0] j, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
        bus.res_job = j; bus.res_c11 = a; bus.res_c12 = b;
        bus.res_c21 = c; bus.res_c22 = d; bus.res_valid = 1'b1;
    endtask

    // Returns one negedge after the accepting clock edge.
    task automatic wait_accept(output int acc_cyc);
        int k = 0;
        while (bus.res_ready !== 1'b1 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk("accept_in_budget", 32'(k < BUDGET), 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_end(input int base_d, input int base_e);
        int k = 0;
        while (dones == base_d && errs == base_e && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk("frame_end_in_budget", 32'(k < BUDGET), 32'd1);
    endtask

    task automatic check_bytes(input string tag);
        int n;
        n = got_q.size() - got_base;
        chk({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[got_base + i], exp_q[i]);
        got_base = got_q.size();
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        busy_q <= bus.tx_busy;
    end

    // Byte logger and protocol watcher.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            starts         <= starts + 1;
            last_start_cyc <= cyc;
            got_q.push_back(bus.tx_byte);
            if (busy_q) viol <= viol + 1;
        end
        if (frame_done === 1'b1) begin
            dones         <= dones + 1;
            last_done_cyc <= cyc;
            if (bus.res_ready) viol <= viol + 1;
        end
        if (frame_err === 1'b1) begin
            errs         <= errs + 1;
            last_err_cyc <= cyc;
        end
    end

    // Model UART: busy rises uart_dly cycles after a start, lasts uart_len.
    initial begin : uart_model
        int d, l;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1 && !uart_dead) begin
                d = uart_dly;
                l = uart_len;
                repeat (d) @(negedge clk);
                uart_busy = 1'b1;
                repeat (l) @(negedge clk);
                uart_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, acc2, bs, bd, be, k;
        logic [7:0] rj, ra, rb, rc, rd;
        bus.res_valid = 1'b0;
        bus.res_job = 8'h00; bus.res_c11 = 8'h00; bus.res_c12 = 8'h00;
        bus.res_c21 = 8'h00; bus.res_c22 = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.res_ready, 1'b0);
        chk("rst_tx_start", bus.tx_start, 1'b0);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.res_ready, 1'b1);

        // Nominal frame; res_c11 changes right after accept
        bs = starts; bd = dones; be = errs;
        drive_result(8'h05, 8'h13, 8'h16, 8'h2B, 8'h32);
        push_frame(8'h05, 8'h13, 8'h16, 8'h2B, 8'h32, 8);
        wait_accept(acc);
        bus.res_c11 = 8'hAA;
        bus.res_valid = 1'b0;
        wait_end(bd, be);
        check_bytes("nominal");
        chk("nominal_starts", starts - bs, 8);
        chk("nominal_done", dones - bd, 1);
        chk("nominal_err", errs - be, 0);

        // Back-pressure: second result held valid during frame 1
        bd = dones; be = errs;
        drive_result(8'h05, 8'h13, 8'h16, 8'h2B, 8'h32);
        push_frame(8'h05, 8'h13, 8'h16, 8'h2B, 8'h32, 8);
        wait_accept(acc);
        drive_result(8'h06, 8'h00, 8'h00, 8'h00, 8'h00);
        push_frame(8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8);
        wait_accept(acc2);
        bus.res_valid = 1'b0;
        chk("bp_accept_after_done", acc2, last_done_cyc + 1);
        wait_end(bd + 1, be);
        check_bytes("backpressure");
        chk("bp_done", dones - bd, 2);

        // Randomized frames over varied UART timing
        for (int r = 0; r < 6; r++) begin
            uart_dly = $urandom_range(1, 3);
            uart_len = $urandom_range(1, 12);
            rj = 8'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            rc = 8'($urandom); rd = 8'($urandom);
            bs = starts; bd = dones; be = errs;
            drive_result(rj, ra, rb, rc, rd);
            push_frame(rj, ra, rb, rc, rd, 8);
            wait_accept(acc);
            drive_result(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            bus.res_valid = 1'b0;
            wait_end(bd, be);
            check_bytes($sformatf("rand%0d", r));
            chk("rand_starts", starts - bs, 8);
            chk("rand_done", dones - bd, 1);
        end
        uart_dly = 1;
        uart_len = 10;

        // Timeout: UART never acknowledges
        uart_dead = 1'b1;
        bs = starts; bd = dones; be = errs;
        rj = 8'($urandom);
        drive_result(rj, 8'h01, 8'h02, 8'h03, 8'h04);
        push_frame(rj, 8'h01, 8'h02, 8'h03, 8'h04, 1);
        wait_accept(acc);
        bus.res_valid = 1'b0;
        wait_end(bd, be);
        chk("to_ready_next", bus.res_ready, 1'b1);
        chk("to_err", errs - be, 1);
        chk("to_done", dones - bd, 0);
        chk("to_starts", starts - bs, 1);
        chk("to_latency", last_err_cyc - last_start_cyc, AT);
        check_bytes("timeout");
        uart_dead = 1'b0;

        // Busy already high at accept
        force_busy = 1'b1;
        bs = starts; bd = dones; be = errs;
        drive_result(8'h3C, 8'h5A, 8'hA5, 8'h0F, 8'hF0);
        push_frame(8'h3C, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8);
        wait_accept(acc);
        bus.res_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("busy_entry_no_start", starts - bs, 0);
        force_busy = 1'b0;
        wait_end(bd, be);
        check_bytes("busy_entry");
        chk("busy_entry_starts", starts - bs, 8);

        // Reset during byte 3
        bs = starts;
        drive_result(8'h77, 8'h11, 8'h22, 8'h33, 8'h44);
        push_frame(8'h77, 8'h11, 8'h22, 8'h33, 8'h44, 4);
        wait_accept(acc);
        bus.res_valid = 1'b0;
        k = 0;
        while (starts < bs + 4 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_reached", 32'(k < BUDGET), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        bd = dones; be = errs;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_start", bus.tx_start, 1'b0);
            chk("rst_mid_ready", bus.res_ready, 1'b0);
        end
        chk("rst_mid_byte", bus.tx_byte, 8'h00);
        rst = 1'b0;
        bs = starts;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_start", starts - bs, 0);
        chk("rst_mid_no_done", dones - bd, 0);
        chk("rst_mid_no_err", errs - be, 0);
        check_bytes("rst_partial");
        bd = dones; be = errs;
        drive_result(8'h78, 8'h55, 8'h66, 8'h77, 8'h88);
        push_frame(8'h78, 8'h55, 8'h66, 8'h77, 8'h88, 8);
        wait_accept(acc);
        bus.res_valid = 1'b0;
        wait_end(bd, be);
        check_bytes("after_rst");

        chk("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/result_framer.md
# result_framer

Downstream stage of the 2x2 matrix-multiply engine. It accepts one finished result set (job id plus c11, c12, c21, c22), wraps it in a fixed 8-byte reply frame, and streams the frame byte-by-byte into the UART transmitter with a start/busy handshake. It sits between `mat_mul` and the `uart` TX side. It replaces the ad-hoc echo of received bytes with a structured reply the host can parse and check.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 16: cycles to wait for `tx_busy` to rise after `tx_start` before the frame is aborted.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `res_valid`  in  1  result set present on `res_job`/`res_c*`.
- `res_ready`  out  1  framer idle; a result is accepted on a cycle where `res_valid & res_ready`.
- `res_job`  in  8  job id echoed in the frame.
- `res_c11`, `res_c12`, `res_c21`, `res_c22`  in  8 each  matrix result bytes.
- `tx_byte`  out  8  byte presented to the UART.
- `tx_start`  out  1  one-cycle request to send `tx_byte`.
- `tx_busy`  in  1  UART is shifting a byte.
- `frame_done`  out  1  one-cycle pulse after the last byte's transmission completes.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted on timeout.

## Operation
- Frame, bytes 0..7: `0xFF` (sync), `0x02` (result tag), job, c11, c12, c21, c22, checksum.
- Checksum = XOR of bytes 1..6 (tag, job, four results).
- All inputs are latched into internal registers on the accept cycle; later input changes do not affect the frame in flight.
- States:
  - IDLE: `res_ready=1`. On accept, capture inputs, set index to 0, compute checksum, and go to SEND.
  - SEND: if `tx_busy=0`, drive `tx_byte` = frame[index] and pulse `tx_start`, then go to WAIT_ACK. Otherwise stay.
  - WAIT_ACK: on `tx_busy=1`, go to WAIT_DONE. If the timeout counter reaches `ACK_TIMEOUT` first, pulse `frame_err` and go to IDLE.
  - WAIT_DONE: on `tx_busy=0`, if index==7 pulse `frame_done` and go to IDLE. Otherwise increment index and go to SEND.
- `tx_byte` holds its last value between sends.
- The index is 3 bits and never wraps mid-frame; it reaches 7 only on the checksum byte.
- Boundary conditions:
  - `res_valid` while not in IDLE: ignored, since `res_ready=0`. The upstream side holds `res_valid`.
  - Simultaneous `frame_done` and a new `res_valid`: not accepted that cycle. Acceptance is earliest on the next cycle, in IDLE.
  - `tx_busy` already high on entry to SEND: wait; no `tx_start` is issued.
  - `rst` mid-frame: abort immediately to IDLE. No `frame_done` or `frame_err`. The remaining bytes are never sent.

## Timing
- Reset values: `tx_start=0`, `tx_byte=0x00`, `frame_done=0`, `frame_err=0`, state IDLE, index 0, timeout counter 0.
- `res_ready=0` while `rst=1`, and 1 from the first cycle after release.
- Accept at cycle T. The first `tx_start` occurs at T+1 if `tx_busy=0`.
- `tx_start` is registered, high for exactly one cycle per byte, and never high while `tx_busy=1` was sampled high in the previous cycle.
- The timeout counter clears on every `tx_start` and counts WAIT_ACK cycles. A `tx_busy` rise in cycle k ≤ `ACK_TIMEOUT` after `tx_start` is accepted.
- `frame_done` is asserted the cycle after `tx_busy` falls for byte 7.
- Minimum frame duration with an ideal UART: 8 × (1 SEND + 1 ACK + UART byte time) cycles.

## Structure
- The shared package (`mat_pkg`) holds:
  - `SYNC_BYTE=8'hFF`
  - `TAG_RESULT=8'h02`
  - `FRAME_LEN=8`
  - the state enum (IDLE, SEND, WAIT_ACK, WAIT_DONE)
- These constants are reused by the host-facing request parser for `0xFF` sync and tag decoding.
- Single module; no sub-module. The frame-byte select is an 8-way mux on the index, kept inline.

## Test plan
- Nominal: job 0x05, c = 0x13, 0x16, 0x2B, 0x32, with a model UART (busy 1 cycle after start, 10 cycles long) → bytes FF 02 05 13 16 2B 32 1B in order, 8 `tx_start` pulses, one `frame_done`, no `frame_err`.
- Back-pressure: `res_valid` held high with a second result (job 0x06, all c=0x00) during frame 1 → frame 1 completes intact; frame 2 is accepted only after `frame_done` and is FF 02 06 00 00 00 00 04.
- Input change after accept: alter `res_c11` to 0xAA the cycle after accept → frame still carries 0x13 and checksum 0x1B.
- Timeout: the UART never raises `tx_busy` → exactly one `tx_start` (byte 0xFF), `frame_err` pulse `ACK_TIMEOUT` cycles later, and `res_ready=1` the next cycle.
- Busy at entry: `tx_busy` forced high for 20 cycles at accept → no `tx_start` until `tx_busy` drops, then the normal sequence follows.
- Reset mid-frame: assert `rst` during byte 3 → `tx_start` stays low and there is no done/err pulse. After release a fresh frame starts from 0xFF.
